// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store port and a loader/DMA port.
// Grants are decided combinationally from the live requests and registered
// state (last winner, DMA burst count). Read data is routed back one cycle
// after the grant through a registered owner flag.
module dmem_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    input  logic [2:0]  core_mode_i,
    input  logic        dma_req_i,
    input  logic        dma_we_i,
    input  logic [31:0] dma_addr_i,
    input  logic [31:0] dma_wdata_i,
    input  logic [2:0]  dma_mode_i,
    input  logic        dma_lock_i,
    output logic        core_gnt_o,
    output logic        dma_gnt_o,
    output logic        core_rvalid_o,
    output logic        dma_rvalid_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        mem_en_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [2:0]  mem_mode_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

    typedef enum logic {
        WIN_CORE = 1'b0,
        WIN_DMA  = 1'b1
    } winner_e;

    winner_e     last_winner_q, last_winner_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_owner_q, rd_owner_d;
    logic        core_gnt_s, dma_gnt_s;
    logic        rvalid_s;

    // Saturating increment of the DMA burst counter at the configured limit.
    function automatic logic [3:0] burst_inc(input logic [3:0] cnt);
        logic [3:0] res;
        if (cnt >= BURST_LIMIT) begin
            res = BURST_LIMIT;
        end else begin
            res = cnt + 4'd1;
        end
        return res;
    endfunction

    // Grant decision: single requester wins at once; ties go to the locked DMA
    // burst until its budget is spent, otherwise round-robin on last winner.
    always_comb begin
        core_gnt_s = 1'b0;
        dma_gnt_s  = 1'b0;
        if (reset_i) begin
            core_gnt_s = 1'b0;
            dma_gnt_s  = 1'b0;
        end else if (core_req_i && dma_req_i) begin
            if (dma_lock_i) begin
                if (burst_cnt_q < BURST_LIMIT) begin
                    dma_gnt_s = 1'b1;
                end else begin
                    core_gnt_s = 1'b1;
                end
            end else if (last_winner_q == WIN_DMA) begin
                core_gnt_s = 1'b1;
            end else begin
                dma_gnt_s = 1'b1;
            end
        end else if (core_req_i) begin
            core_gnt_s = 1'b1;
        end else if (dma_req_i) begin
            dma_gnt_s = 1'b1;
        end else begin
            core_gnt_s = 1'b0;
            dma_gnt_s  = 1'b0;
        end
    end

    // Memory-side mux: forward the winner's payload, all zero when idle.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = 32'd0;
        mem_wdata_o = 32'd0;
        mem_mode_o  = 3'd0;
        if (core_gnt_s) begin
            mem_we_o    = core_we_i;
            mem_addr_o  = core_addr_i;
            mem_wdata_o = core_wdata_i;
            mem_mode_o  = core_mode_i;
        end else if (dma_gnt_s) begin
            mem_we_o    = dma_we_i;
            mem_addr_o  = dma_addr_i;
            mem_wdata_o = dma_wdata_i;
            mem_mode_o  = dma_mode_i;
        end else begin
            mem_we_o    = 1'b0;
            mem_addr_o  = 32'd0;
            mem_wdata_o = 32'd0;
            mem_mode_o  = 3'd0;
        end
    end

    // Next-state: last winner, burst budget and the read-return owner flag.
    always_comb begin
        last_winner_d = last_winner_q;
        burst_cnt_d   = burst_cnt_q;
        rd_pend_d     = 1'b0;
        rd_owner_d    = 1'b0;

        if (core_gnt_s) begin
            last_winner_d = WIN_CORE;
        end else if (dma_gnt_s) begin
            last_winner_d = WIN_DMA;
        end else begin
            last_winner_d = last_winner_q;
        end

        // A DMA grant counts against the burst only while the core is waiting.
        if (dma_gnt_s && core_req_i && dma_lock_i) begin
            burst_cnt_d = burst_inc(burst_cnt_q);
        end else if (core_gnt_s || !dma_lock_i || !core_req_i) begin
            burst_cnt_d = 4'd0;
        end else begin
            burst_cnt_d = burst_cnt_q;
        end

        if ((core_gnt_s || dma_gnt_s) && !mem_we_o) begin
            rd_pend_d  = 1'b1;
            rd_owner_d = dma_gnt_s;
        end else begin
            rd_pend_d  = 1'b0;
            rd_owner_d = 1'b0;
        end
    end

    // State registers with synchronous reset; core wins the first tie.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            last_winner_q <= WIN_DMA;
            burst_cnt_q   <= 4'd0;
            rd_pend_q     <= 1'b0;
            rd_owner_q    <= 1'b0;
        end else begin
            last_winner_q <= last_winner_d;
            burst_cnt_q   <= burst_cnt_d;
            rd_pend_q     <= rd_pend_d;
            rd_owner_q    <= rd_owner_d;
        end
    end

    // A read return landing in a reset cycle is dropped.
    assign rvalid_s      = rd_pend_q && !reset_i;
    assign core_rvalid_o = rvalid_s && !rd_owner_q;
    assign dma_rvalid_o  = rvalid_s && rd_owner_q;
    assign rdata_o       = rvalid_s ? mem_rdata_i : 32'd0;

    assign core_gnt_o = core_gnt_s;
    assign dma_gnt_o  = dma_gnt_s;
    assign mem_en_o   = core_gnt_s || dma_gnt_s;
    assign stall_o    = core_req_i && !core_gnt_s && !reset_i;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by
// constrained-random traffic, all compared against a rule-level reference.
module tb_dmem_arbiter;

    localparam int MAX_BURST = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        core_req_i, core_we_i;
    logic [31:0] core_addr_i, core_wdata_i;
    logic [2:0]  core_mode_i;
    logic        dma_req_i, dma_we_i, dma_lock_i;
    logic [31:0] dma_addr_i, dma_wdata_i;
    logic [2:0]  dma_mode_i;
    logic        core_gnt_o, dma_gnt_o, core_rvalid_o, dma_rvalid_o, stall_o;
    logic [31:0] rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [2:0]  mem_mode_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: who was granted last, DMA grants in current
    // locked burst, and the list of reads waiting to return (owner 1 = DMA).
    bit  m_last_dma   = 1'b1;
    int  m_burst      = 0;
    bit  m_pend_q[$];
    // Expectations for the current cycle, used when advancing the model.
    bit  e_cg, e_dg, e_we;

    dmem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .core_req_i(core_req_i), .core_we_i(core_we_i), .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i), .core_mode_i(core_mode_i),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_mode_i(dma_mode_i), .dma_lock_i(dma_lock_i),
        .core_gnt_o(core_gnt_o), .dma_gnt_o(dma_gnt_o),
        .core_rvalid_o(core_rvalid_o), .dma_rvalid_o(dma_rvalid_o), .rdata_o(rdata_o),
        .stall_o(stall_o), .mem_en_o(mem_en_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_mode_o(mem_mode_o),
        .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_core(input bit req, input bit we, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [2:0] mode);
        core_req_i = req; core_we_i = we; core_addr_i = addr;
        core_wdata_i = wd; core_mode_i = mode;
    endtask

    task automatic set_dma(input bit req, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [2:0] mode, input bit lock);
        dma_req_i = req; dma_we_i = we; dma_addr_i = addr;
        dma_wdata_i = wd; dma_mode_i = mode; dma_lock_i = lock;
    endtask

    // Let combinational outputs settle, then compare every output to the model.
    task automatic settle_check();
        bit          tie, has_ret, ret_dma;
        logic [31:0] ea, ewd;
        logic [2:0]  em;
        #2;
        e_cg = 1'b0; e_dg = 1'b0;
        if (!reset_i) begin
            tie = core_req_i && dma_req_i;
            if (tie && dma_lock_i)      begin e_dg = (m_burst < MAX_BURST); e_cg = !e_dg; end
            else if (tie)               begin e_cg = m_last_dma; e_dg = !m_last_dma; end
            else                        begin e_cg = core_req_i; e_dg = dma_req_i; end
        end
        e_we = e_cg ? core_we_i : (e_dg ? dma_we_i : 1'b0);
        ea   = e_cg ? core_addr_i  : (e_dg ? dma_addr_i  : 32'd0);
        ewd  = e_cg ? core_wdata_i : (e_dg ? dma_wdata_i : 32'd0);
        em   = e_cg ? core_mode_i  : (e_dg ? dma_mode_i  : 3'd0);
        has_ret = (m_pend_q.size() > 0) && !reset_i;
        ret_dma = (m_pend_q.size() > 0) ? m_pend_q[0] : 1'b0;

        chk("core_gnt",    core_gnt_o,  {31'd0, e_cg});
        chk("dma_gnt",     dma_gnt_o,   {31'd0, e_dg});
        chk("stall",       stall_o,     {31'd0, (core_req_i && !e_cg && !reset_i)});
        chk("mem_en",      mem_en_o,    {31'd0, (e_cg || e_dg)});
        chk("mem_we",      mem_we_o,    {31'd0, e_we});
        chk("mem_addr",    mem_addr_o,  ea);
        chk("mem_wdata",   mem_wdata_o, ewd);
        chk("mem_mode",    mem_mode_o,  {29'd0, em});
        chk("core_rvalid", core_rvalid_o, {31'd0, (has_ret && !ret_dma)});
        chk("dma_rvalid",  dma_rvalid_o,  {31'd0, (has_ret && ret_dma)});
        chk("rdata",       rdata_o,     has_ret ? mem_rdata_i : 32'd0);
    endtask

    // Clock edge, then apply the arbitration rules to the model state.
    task automatic advance();
        @(posedge clk_i);
        if (m_pend_q.size() > 0) void'(m_pend_q.pop_front());
        if (reset_i) begin
            m_last_dma = 1'b1;
            m_burst    = 0;
            m_pend_q.delete();
        end else begin
            if (e_cg || e_dg) m_last_dma = e_dg;
            if ((e_cg || e_dg) && !e_we) m_pend_q.push_back(e_dg);
            if (e_dg && core_req_i && dma_lock_i)
                m_burst = (m_burst + 1 > MAX_BURST) ? MAX_BURST : m_burst + 1;
            else
                m_burst = 0;
        end
        @(negedge clk_i);
    endtask

    task automatic step();
        settle_check();
        advance();
    endtask

    initial begin
        logic [3:0] alt_pat;
        logic [9:0] burst_pat;
        bit         c_hold, d_hold;

        // Reset with both sides requesting: nothing may be granted.
        reset_i = 1'b1;
        mem_rdata_i = 32'hA5A5_0001;
        set_core(1'b1, 1'b0, 32'h10, 32'd0, 3'd2);
        set_dma(1'b1, 1'b0, 32'h20, 32'd0, 3'd2, 1'b0);
        step();
        step();
        reset_i = 1'b0;

        // Continuous tie without lock: core, dma, core, dma.
        alt_pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            mem_rdata_i = $urandom;
            settle_check();
            chk("alt_dma_gnt", dma_gnt_o, {31'd0, alt_pat[3-i]});
            chk("alt_stall",   stall_o,   {31'd0, alt_pat[3-i]});
            advance();
        end

        // Drain and clear the burst counter, then a locked 10-cycle tie.
        set_core(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        step();
        step();
        set_core(1'b1, 1'b0, 32'h44, 32'd0, 3'd2);
        set_dma(1'b1, 1'b1, 32'h88, 32'h5555_AAAA, 3'd2, 1'b1);
        burst_pat = 10'b1111011110;
        for (int i = 0; i < 10; i++) begin
            mem_rdata_i = $urandom;
            settle_check();
            chk("burst_dma_gnt", dma_gnt_o, {31'd0, burst_pat[9-i]});
            advance();
        end

        // Core-only read returning 0xDEADBEEF next cycle.
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        set_core(1'b1, 1'b0, 32'h100, 32'd0, 3'b010);
        step();
        set_core(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        mem_rdata_i = 32'hDEAD_BEEF;
        settle_check();
        chk("core_read_rvalid", core_rvalid_o, 32'd1);
        chk("core_read_rdata",  rdata_o, 32'hDEAD_BEEF);
        advance();

        // DMA write: no read return afterwards.
        set_dma(1'b1, 1'b1, 32'h40, 32'h1234_5678, 3'b000, 1'b0);
        settle_check();
        chk("dma_write_wdata", mem_wdata_o, 32'h1234_5678);
        chk("dma_write_we",    mem_we_o, 32'd1);
        advance();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        mem_rdata_i = 32'h0BAD_F00D;
        settle_check();
        chk("dma_write_no_rvalid", {30'd0, core_rvalid_o, dma_rvalid_o}, 32'd0);
        advance();

        // Core read then DMA read on consecutive cycles, returns in order.
        set_core(1'b1, 1'b0, 32'h200, 32'd0, 3'b010);
        step();
        set_core(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_dma(1'b1, 1'b0, 32'h300, 32'd0, 3'b001, 1'b0);
        mem_rdata_i = 32'h1111_2222;
        settle_check();
        chk("b2b_core_rvalid", core_rvalid_o, 32'd1);
        chk("b2b_core_rdata",  rdata_o, 32'h1111_2222);
        advance();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        mem_rdata_i = 32'h3333_4444;
        settle_check();
        chk("b2b_dma_rvalid", dma_rvalid_o, 32'd1);
        chk("b2b_dma_rdata",  rdata_o, 32'h3333_4444);
        advance();

        // Make DMA the last winner, read, then reset during the return cycle.
        set_core(1'b1, 1'b0, 32'h500, 32'd0, 3'd2);
        step();
        set_core(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_dma(1'b1, 1'b0, 32'h600, 32'd0, 3'd2, 1'b0);
        step();
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        reset_i = 1'b1;
        mem_rdata_i = 32'h7777_8888;
        settle_check();
        chk("rst_drop_rvalid", {30'd0, core_rvalid_o, dma_rvalid_o}, 32'd0);
        advance();
        reset_i = 1'b0;
        set_core(1'b1, 1'b0, 32'h700, 32'd0, 3'd2);
        set_dma(1'b1, 1'b0, 32'h800, 32'd0, 3'd2, 1'b0);
        settle_check();
        chk("rst_first_tie_core", core_gnt_o, 32'd1);
        advance();
        set_core(1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_dma(1'b0, 1'b0, 32'd0, 32'd0, 3'd0, 1'b0);
        step();

        // Random traffic; stalled requesters hold their request and payload.
        c_hold = 1'b0;
        d_hold = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!c_hold)
                set_core($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                         $urandom, 3'($urandom_range(0, 7)));
            if (!d_hold)
                set_dma($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom,
                        $urandom, 3'($urandom_range(0, 7)), $urandom_range(0, 3) != 0);
            reset_i = ($urandom_range(0, 49) == 0);
            mem_rdata_i = $urandom;
            settle_check();
            c_hold = core_req_i && !e_cg && !reset_i;
            d_hold = dma_req_i && !e_dg && !reset_i;
            advance();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
